// File: rtl/axicb_mst_wr_sched_if.sv
// Write-scheduler handshake bundle: master requests, AW/B handshakes,
// and the grant/status outputs returned by the scheduler.
interface axicb_mst_wr_sched_if #(
  parameter int MST_NB = 4
);
  logic [MST_NB-1:0] req;
  logic              aw_hs;
  logic [MST_NB-1:0] b_hs;
  logic [MST_NB-1:0] grant;
  logic              grant_valid;
  logic [MST_NB-1:0] ostd_full;
  logic              ostd_err;
  logic              timeout_err;

  modport master (
    output req, aw_hs, b_hs,
    input  grant, grant_valid, ostd_full, ostd_err, timeout_err
  );

  modport slave (
    input  req, aw_hs, b_hs,
    output grant, grant_valid, ostd_full, ostd_err, timeout_err
  );
endinterface

// File: rtl/axicb_mst_wr_sched.sv
// AW-channel scheduler for a crossbar slave port: priority + round-robin
// arbitration, per-master outstanding-write tracking and an AW-stall watchdog.
module axicb_mst_wr_sched #(
  parameter int MST_NB         = 4,
  parameter int MST0_PRIORITY  = 0,
  parameter int MST1_PRIORITY  = 0,
  parameter int MST2_PRIORITY  = 0,
  parameter int MST3_PRIORITY  = 0,
  parameter int OSTDREQ_NUM    = 4,
  parameter int TIMEOUT_ENABLE = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 srst,
  axicb_mst_wr_sched_if.slave  bus
);

  localparam int IDX_W = (MST_NB > 1) ? $clog2(MST_NB) : 1;
  localparam int CNT_W = $clog2(OSTDREQ_NUM + 1);
  localparam int PRIO [0:3] = '{MST0_PRIORITY, MST1_PRIORITY, MST2_PRIORITY, MST3_PRIORITY};

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t            r_state, w_state_nxt;
  logic [MST_NB-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]  r_last_gnt, w_last_gnt_nxt;
  logic [CNT_W-1:0]  r_cnt [MST_NB];
  logic              r_ostd_err;
  logic [MST_NB-1:0] w_full, w_elig, w_inc, w_underflow;
  logic [IDX_W-1:0]  w_winner;

  always_comb begin
    for (int i = 0; i < MST_NB; i++) begin
      w_full[i]      = (r_cnt[i] == CNT_W'(OSTDREQ_NUM));
      w_inc[i]       = (r_state == GRANTED) && bus.aw_hs && r_grant[i];
      w_underflow[i] = bus.b_hs[i] && !w_inc[i] && (r_cnt[i] == '0);
    end
  end

  assign w_elig = bus.req & ~w_full;

  // Highest priority level present first, then rotate from last_gnt+1.
  always_comb begin
    int                top;
    logic              found;
    logic [MST_NB-1:0] cand;
    top      = 0;
    found    = 1'b0;
    cand     = '0;
    w_winner = r_last_gnt;
    for (int i = 0; i < MST_NB; i++)
      if (w_elig[i] && (PRIO[i] > top)) top = PRIO[i];
    for (int i = 0; i < MST_NB; i++)
      cand[i] = w_elig[i] && (PRIO[i] == top);
    for (int k = 1; k <= MST_NB; k++)
      for (int i = 0; i < MST_NB; i++)
        if (!found && cand[i] && (i == ((int'(r_last_gnt) + k) % MST_NB))) begin
          found    = 1'b1;
          w_winner = IDX_W'(i);
        end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_gnt_nxt = r_last_gnt;
    case (r_state)
      IDLE: begin
        if (|w_elig) begin
          w_state_nxt    = GRANTED;
          w_grant_nxt    = MST_NB'(1) << w_winner;
          w_last_gnt_nxt = w_winner;
        end
      end
      GRANTED: begin
        // Dropping req while granted abandons the grant without counting it.
        if (bus.aw_hs || !(|(bus.req & r_grant))) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_last_gnt <= IDX_W'(MST_NB - 1);
    end else if (srst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_last_gnt <= IDX_W'(MST_NB - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_last_gnt <= w_last_gnt_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < MST_NB; i++) r_cnt[i] <= '0;
      r_ostd_err <= 1'b0;
    end else if (srst) begin
      for (int i = 0; i < MST_NB; i++) r_cnt[i] <= '0;
      r_ostd_err <= 1'b0;
    end else begin
      for (int i = 0; i < MST_NB; i++) begin
        if (w_inc[i] && !bus.b_hs[i])
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (!w_inc[i] && bus.b_hs[i] && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
      r_ostd_err <= |w_underflow;
    end
  end

  generate
    if (TIMEOUT_ENABLE != 0) begin : g_wdog
      localparam int WD_W = $clog2(TIMEOUT_CYCLES);
      logic [WD_W-1:0] r_wdog;

      // Counter holds the GRANTED cycle index minus one, wrapping every TIMEOUT_CYCLES.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
          r_wdog <= '0;
        else if (srst)
          r_wdog <= '0;
        else if ((r_state != GRANTED) || bus.aw_hs)
          r_wdog <= '0;
        else if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1))
          r_wdog <= '0;
        else
          r_wdog <= r_wdog + WD_W'(1);
      end

      assign bus.timeout_err = (r_state == GRANTED) && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wdog
      assign bus.timeout_err = 1'b0;
    end
  endgenerate

  assign bus.grant       = r_grant;
  assign bus.grant_valid = (r_state == GRANTED);
  assign bus.ostd_full   = w_full;
  assign bus.ostd_err    = r_ostd_err;

endmodule

// File: tb/tb_axicb_mst_wr_sched.sv
// Bench for axicb_mst_wr_sched: two instances (flat priorities, master 2 boosted)
// share stimulus and are compared every cycle against a transaction-level model.
module tb_axicb_mst_wr_sched;

  localparam int N    = 4;
  localparam int OSTD = 4;
  localparam int TC   = 8;
  localparam int PRIO_M [2][4] = '{'{0, 0, 0, 0}, '{0, 0, 1, 0}};

  logic aclk;
  logic aresetn;
  logic srst;

  axicb_mst_wr_sched_if #(.MST_NB(N)) bus0 ();
  axicb_mst_wr_sched_if #(.MST_NB(N)) bus1 ();

  axicb_mst_wr_sched #(
    .MST_NB(N), .MST0_PRIORITY(0), .MST1_PRIORITY(0), .MST2_PRIORITY(0), .MST3_PRIORITY(0),
    .OSTDREQ_NUM(OSTD), .TIMEOUT_ENABLE(1), .TIMEOUT_CYCLES(TC)
  ) u_dut0 (.aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(bus0));

  axicb_mst_wr_sched #(
    .MST_NB(N), .MST0_PRIORITY(0), .MST1_PRIORITY(0), .MST2_PRIORITY(1), .MST3_PRIORITY(0),
    .OSTDREQ_NUM(OSTD), .TIMEOUT_ENABLE(1), .TIMEOUT_CYCLES(TC)
  ) u_dut1 (.aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(bus1));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: granted master (-1 = none), rotation pointer, per-master
  // outstanding writes, 1-based GRANTED cycle index, pending ostd_err.
  int g     [2];
  int last  [2];
  int cnt   [2][4];
  int gcyc  [2];
  int oerr  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return |(v & (4'b0001 << i));
  endfunction

  function automatic int pick(input int m, input logic [3:0] elig);
    int idx;
    for (int lvl = 3; lvl >= 0; lvl--)
      for (int k = 1; k <= N; k++) begin
        idx = (last[m] + k) % N;
        if (bit_of(elig, idx) && PRIO_M[m][idx] == lvl) return idx;
      end
    return -1;
  endfunction

  task automatic model_reset(input int m);
    g[m]    = -1;
    last[m] = N - 1;
    gcyc[m] = 0;
    oerr[m] = 0;
    for (int i = 0; i < N; i++) cnt[m][i] = 0;
  endtask

  task automatic model_step(input int m, input logic [3:0] rq, input logic aw, input logic [3:0] bh);
    logic [3:0] elig;
    int ng;
    int under;
    bit acc;
    for (int i = 0; i < N; i++) elig[i] = rq[i] && (cnt[m][i] != OSTD);
    if (g[m] < 0) begin
      ng = (elig != 4'b0) ? pick(m, elig) : -1;
      if (ng >= 0) begin
        last[m] = ng;
        gcyc[m] = 1;
      end
    end else if (aw || !bit_of(rq, g[m])) begin
      ng = -1;
    end else begin
      ng = g[m];
      gcyc[m]++;
    end
    under = 0;
    for (int i = 0; i < N; i++) begin
      acc = (g[m] == i) && aw;
      if (acc && !bh[i]) cnt[m][i]++;
      else if (bh[i] && !acc) begin
        if (cnt[m][i] == 0) under = 1;
        else cnt[m][i]--;
      end
    end
    g[m]    = ng;
    oerr[m] = under;
  endtask

  task automatic check_one(input string p, input int m, input logic [3:0] gr, input logic gv,
                           input logic [3:0] fu, input logic oe, input logic te);
    logic [3:0] eg;
    logic [3:0] ef;
    eg = (g[m] < 0) ? 4'b0 : (4'b0001 << g[m]);
    for (int i = 0; i < N; i++) ef[i] = (cnt[m][i] == OSTD);
    chk({p, ".grant"}, 32'(gr), 32'(eg));
    chk({p, ".grant_valid"}, 32'(gv), 32'(g[m] >= 0));
    chk({p, ".ostd_full"}, 32'(fu), 32'(ef));
    chk({p, ".ostd_err"}, 32'(oe), 32'(oerr[m]));
    chk({p, ".timeout_err"}, 32'(te), 32'((g[m] >= 0) && (gcyc[m] % TC == 0)));
  endtask

  task automatic check_model();
    check_one("d0", 0, bus0.grant, bus0.grant_valid, bus0.ostd_full, bus0.ostd_err, bus0.timeout_err);
    check_one("d1", 1, bus1.grant, bus1.grant_valid, bus1.ostd_full, bus1.ostd_err, bus1.timeout_err);
  endtask

  // Drive one cycle of inputs at the negedge, advance the model at the posedge,
  // then compare at the following negedge.
  task automatic step(input logic [3:0] rq, input logic aw, input logic [3:0] bh, input logic sr);
    bus0.req = rq;  bus1.req = rq;
    bus0.aw_hs = aw; bus1.aw_hs = aw;
    bus0.b_hs = bh; bus1.b_hs = bh;
    srst = sr;
    @(posedge aclk);
    for (int m = 0; m < 2; m++) begin
      if (sr) model_reset(m);
      else model_step(m, rq, aw, bh);
    end
    @(negedge aclk);
    check_model();
  endtask

  initial begin
    logic [3:0] rq;
    logic [3:0] bh;
    logic       aw;
    logic       sr;
    int         awp;
    logic [3:0] seq0 [9];
    seq0 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    aresetn = 1'b0;
    srst    = 1'b0;
    bus0.req = '0; bus0.aw_hs = 1'b0; bus0.b_hs = '0;
    bus1.req = '0; bus1.aw_hs = 1'b0; bus1.b_hs = '0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge aclk);
    check_model();
    aresetn = 1'b1;
    @(negedge aclk);
    check_model();

    // Flat round robin on d0; d1 keeps master 2 until it is full.
    for (int s = 0; s < 9; s++) begin
      step(4'b1111, 1'b1, 4'b0000, 1'b0);
      chk($sformatf("rr_seq[%0d]", s), 32'(bus0.grant), 32'(seq0[s]));
      if (s % 2 == 0 && s < 8) chk($sformatf("prio_m2[%0d]", s), 32'(bus1.grant), 32'(4'b0100));
    end
    chk("prio_m2_full", 32'(bus1.ostd_full[2]), 32'(1));
    chk("prio_after_full", 32'(bus1.grant[2]), 32'(0));

    // Fill master 0, then exercise lone and simultaneous B handshakes.
    step(4'b0000, 1'b0, 4'b0000, 1'b1);
    repeat (8) step(4'b0001, 1'b1, 4'b0000, 1'b0);
    chk("m0_full", 32'(bus0.ostd_full[0]), 32'(1));
    step(4'b0001, 1'b1, 4'b0000, 1'b0);
    chk("full_no_grant", 32'(bus0.grant), 32'(0));
    step(4'b0000, 1'b0, 4'b0001, 1'b0);
    chk("lone_b_unfull", 32'(bus0.ostd_full[0]), 32'(0));
    step(4'b0001, 1'b0, 4'b0000, 1'b0);
    step(4'b0001, 1'b1, 4'b0001, 1'b0);
    chk("aw_b_same_cycle", 32'(bus0.ostd_full[0]), 32'(0));
    step(4'b0001, 1'b0, 4'b0000, 1'b0);
    step(4'b0001, 1'b1, 4'b0000, 1'b0);
    chk("refill_m0", 32'(bus0.ostd_full[0]), 32'(1));

    // B on an empty counter.
    step(4'b0000, 1'b0, 4'b0000, 1'b1);
    step(4'b0000, 1'b0, 4'b0010, 1'b0);
    chk("underflow_pulse", 32'(bus0.ostd_err), 32'(1));
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
    chk("underflow_clear", 32'(bus0.ostd_err), 32'(0));

    // Watchdog: master 3 stalls with no AW handshake.
    step(4'b0000, 1'b0, 4'b0000, 1'b1);
    for (int n = 1; n <= 24; n++) begin
      step(4'b1000, 1'b0, 4'b0000, 1'b0);
      chk($sformatf("wdog_te[%0d]", n), 32'(bus0.timeout_err), 32'(n % 8 == 0));
      chk($sformatf("wdog_gnt[%0d]", n), 32'(bus0.grant), 32'(4'b1000));
    end

    // Asynchronous reset while granted with outstanding counts.
    step(4'b0000, 1'b0, 4'b0000, 1'b1);
    repeat (8) step(4'b0001, 1'b1, 4'b0000, 1'b0);
    step(4'b0110, 1'b0, 4'b0000, 1'b0);
    chk("pre_rst_granted", 32'(bus0.grant_valid), 32'(1));
    aresetn = 1'b0;
    #1;
    chk("arst_grant", 32'(bus0.grant), 32'(0));
    chk("arst_gv", 32'(bus0.grant_valid), 32'(0));
    chk("arst_full", 32'(bus0.ostd_full), 32'(0));
    model_reset(0);
    model_reset(1);
    @(negedge aclk);
    check_model();
    aresetn = 1'b1;
    step(4'b1111, 1'b0, 4'b0000, 1'b0);
    chk("post_rst_first", 32'(bus0.grant), 32'(4'b0001));

    // Randomized traffic with alternating AW acceptance rates.
    rq = 4'b0;
    for (int blk = 0; blk < 24; blk++) begin
      awp = (blk % 3 == 0) ? 75 : ((blk % 3 == 1) ? 25 : 2);
      for (int c = 0; c < 64; c++) begin
        if ($urandom_range(0, 7) == 0) rq = 4'($urandom);
        aw = ($urandom_range(0, 99) < awp);
        for (int i = 0; i < N; i++) bh[i] = ($urandom_range(0, 5) == 0);
        sr = ($urandom_range(0, 249) == 0);
        step(rq, aw, bh, sr);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
